multi_chan_driver: RTL and testbench
====================================

MULTI_CHAN_DRIVER -- requirements
Module: multi_chan_driver

Interface
REQ-001 Parameter NUM_CH, default 4, number of input stimulus channels (2..16).
REQ-002 Parameter DATA_W, default 8, payload width per channel in bits.
REQ-003 Parameter DEPTH, default 4, per-channel FIFO depth in words (power of 2, >=2).
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 in_valid  input  NUM_CH  per-channel word valid.
REQ-007 in_data  input  NUM_CH*DATA_W  channel i occupies bits [i*DATA_W +: DATA_W].
REQ-008 in_ready  output  NUM_CH  per-channel FIFO not full.
REQ-009 ch_en  input  NUM_CH  per-channel arbitration enable.
REQ-010 prio_mode  input  1  0 = round-robin, 1 = fixed priority (lowest index wins).
REQ-011 out_valid  output  1  registered output word valid.
REQ-012 out_data  output  DATA_W  registered output payload.
REQ-013 out_ch  output  $clog2(NUM_CH)  source channel of out_data.
REQ-014 out_ready  input  1  downstream accept.
REQ-015 txn_count  output  16  count of completed output transfers.

Function
REQ-016 Push to FIFO i SHALL occur on an edge where in_valid[i] && in_ready[i].
REQ-017 in_ready[i] SHALL equal !full[i], decoded from registered state only, with no dependency on out_ready or arbitration.
REQ-018 A full FIFO SHALL refuse a push even if it is popped on the same edge; a non-full FIFO SHALL support simultaneous push and pop with its occupancy unchanged.
REQ-019 FIFO read/write pointers SHALL wrap modulo DEPTH; occupancy SHALL range 0..DEPTH, with full at DEPTH and empty at 0.
REQ-020 Channel i SHALL be eligible when its FIFO is non-empty and ch_en[i]=1; disabled channels SHALL still accept pushes.
REQ-021 The output register SHALL load on an edge where (!out_valid || out_ready) and at least one channel is eligible, popping exactly one word from the granted FIFO.
REQ-022 out_valid SHALL deassert on an edge where out_valid && out_ready and no channel is eligible.
REQ-023 While out_valid && !out_ready, out_data, out_ch and out_valid SHALL hold stable and no FIFO SHALL be popped.
REQ-024 Round-robin (prio_mode=0): grant SHALL go to the first eligible channel strictly after last_grant, wrapping from NUM_CH-1 to 0.
REQ-025 Fixed priority (prio_mode=1): grant SHALL go to the lowest-index eligible channel.
REQ-026 last_grant SHALL update on every grant in both modes; a prio_mode change SHALL take effect at the next grant decision.
REQ-027 Latency: a word pushed into an empty FIFO at edge N, with the output register free and the channel winning arbitration, SHALL be presented with out_valid=1 after edge N+1.
REQ-028 Sustained throughput SHALL be one word per cycle when out_ready=1 and any channel is continuously eligible.
REQ-029 Per-channel ordering SHALL be strictly FIFO; no word SHALL be dropped or duplicated.
REQ-030 txn_count SHALL increment by 1 on each edge where out_valid && out_ready, wrapping from 16'hFFFF to 0.

Reset
REQ-031 On an edge where reset=1, all FIFOs SHALL become empty, out_valid=0, out_data=0, out_ch=0, txn_count=0, and last_grant=NUM_CH-1 so that channel 0 is granted first.
REQ-032 While reset=1, in_ready SHALL be all-ones from the cycle after the first reset edge, and pushes presented during reset SHALL be discarded.
REQ-033 Reset asserted mid-transfer SHALL discard all buffered and presented words, and txn_count SHALL NOT increment on that edge.

Verification
REQ-034 Single word: ch2 pushes 0xA5 at edge N, out_ready=1 -> out_valid=1, out_data=0xA5, out_ch=2 after edge N+1; txn_count=1 after edge N+2.
REQ-035 Round-robin: all 4 channels hold 2 words, prio_mode=0, out_ready=1 -> out_ch sequence 0,1,2,3,0,1,2,3 with no idle cycles.
REQ-036 Fixed priority: ch0 and ch3 each hold 3 words, prio_mode=1 -> out_ch sequence 0,0,0,3,3,3.
REQ-037 Backpressure/full: out_ready=0, ch1 pushes 6 words -> 5 accepted (1 in the output register, 4 in the FIFO); in_ready[1]=0 once full; out_data held stable; after release, words drain in order.
REQ-038 Mask and reset: ch_en=4'b1110 with ch0 holding data -> ch0 is never granted; reset mid-stream -> out_valid=0 and txn_count=0 after the reset edge, and all in_ready=1.

Source files
------------

// File: rtl/multi_chan_driver.sv
// multi_chan_driver
//
// Purpose: gathers words from NUM_CH input channels, each buffered in its own
// DEPTH-word FIFO. The words are merged onto a single registered output
// stream. Arbitration is round-robin or fixed priority (lowest index wins), and
// each channel can be masked out of arbitration.
//
// Ports:
//   clk        rising-edge clock
//   reset      synchronous active-high reset
//   in_valid   per-channel word valid
//   in_data    per-channel payload; channel i at [i*DATA_W +: DATA_W]
//   in_ready   per-channel "FIFO not full"
//   ch_en      per-channel arbitration enable (pushes are accepted regardless)
//   prio_mode  0 = round-robin, 1 = fixed priority
//   out_valid  registered output word valid
//   out_data   registered output payload
//   out_ch     source channel of out_data
//   out_ready  downstream accept
//   txn_count  count of completed output transfers (wraps at 16 bits)
//
// Handshake: a word moves across an interface on a rising edge where valid and
// ready are both high. A producer need not wait for ready before raising
// valid. in_ready depends only on registered FIFO occupancy. While out_valid
// is high and out_ready is low, the output word holds stable.

module multi_chan_driver #(
  parameter int NUM_CH = 4,
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_CH-1:0]          in_valid,
  input  logic [NUM_CH*DATA_W-1:0]   in_data,
  output logic [NUM_CH-1:0]          in_ready,
  input  logic [NUM_CH-1:0]          ch_en,
  input  logic                       prio_mode,
  output logic                       out_valid,
  output logic [DATA_W-1:0]          out_data,
  output logic [$clog2(NUM_CH)-1:0]  out_ch,
  input  logic                       out_ready,
  output logic [15:0]                txn_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(NUM_CH);

  // Per-channel FIFO storage and pointers
  logic [DATA_W-1:0] r_mem   [NUM_CH][DEPTH];
  logic [AW-1:0]     r_wptr  [NUM_CH];
  logic [AW-1:0]     r_rptr  [NUM_CH];
  logic [AW:0]       r_count [NUM_CH];

  // Output register and arbitration history
  logic              r_out_valid;
  logic [DATA_W-1:0] r_out_data;
  logic [CW-1:0]     r_out_ch;
  logic [CW-1:0]     r_last_grant;
  logic [15:0]       r_txn_count;

  logic [NUM_CH-1:0] w_full;
  logic [NUM_CH-1:0] w_elig;
  logic [NUM_CH-1:0] w_push;
  logic [NUM_CH-1:0] w_pop;
  logic [CW-1:0]     w_rr_grant;
  logic [CW-1:0]     w_fp_grant;
  logic [CW-1:0]     w_grant;
  logic              w_any_elig;
  logic              w_load;
  logic              w_xfer;
  logic [DATA_W-1:0] w_rd_data;

  // FIFO status decoded purely from registered occupancy
  always_comb begin
    w_full = '0;
    w_elig = '0;
    w_push = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      w_full[i] = (r_count[i] == (AW+1)'(DEPTH));
      w_elig[i] = (r_count[i] != '0) && ch_en[i];
      // A full FIFO refuses the push even if it is being popped this edge
      w_push[i] = in_valid[i] && !w_full[i];
    end
  end

  assign in_ready = ~w_full;

  // Arbitration
  always_comb begin
    int d;
    int best_d;
    w_fp_grant = '0;
    w_rr_grant = '0;
    d          = 0;
    best_d     = NUM_CH + 1;
    // Fixed priority: scan downward so the lowest eligible index is written last
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      if (w_elig[k]) w_fp_grant = CW'(k);
    end
    // Round-robin: distance 1..NUM_CH past last_grant. The last-granted channel
    // itself sits at distance NUM_CH, so it has the lowest priority.
    for (int c = 0; c < NUM_CH; c++) begin
      d = c - int'(r_last_grant);
      if (d <= 0) d = d + NUM_CH;
      if (w_elig[c] && (d < best_d)) begin
        best_d     = d;
        w_rr_grant = CW'(c);
      end
    end
    w_grant = prio_mode ? w_fp_grant : w_rr_grant;
  end

  assign w_any_elig = |w_elig;
  assign w_xfer     = r_out_valid && out_ready;
  assign w_load     = (!r_out_valid || out_ready) && w_any_elig;
  assign w_rd_data  = r_mem[w_grant][r_rptr[w_grant]];

  always_comb begin
    w_pop = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      w_pop[i] = w_load && (w_grant == CW'(i));
    end
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_CH; i++) begin
        r_wptr[i]  <= '0;
        r_rptr[i]  <= '0;
        r_count[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (w_push[i]) r_wptr[i] <= r_wptr[i] + AW'(1);
        if (w_pop[i])  r_rptr[i] <= r_rptr[i] + AW'(1);
        case ({w_push[i], w_pop[i]})
          2'b10:   r_count[i] <= r_count[i] + (AW+1)'(1);
          2'b01:   r_count[i] <= r_count[i] - (AW+1)'(1);
          default: r_count[i] <= r_count[i];
        endcase
      end
    end
  end

  // FIFO storage has no reset; the pointers define which entries are valid
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_CH; i++) begin
      if (!reset && w_push[i]) begin
        r_mem[i][r_wptr[i]] <= in_data[i*DATA_W +: DATA_W];
      end
    end
  end

  // Output register, grant history and transfer counter
  always_ff @(posedge clk) begin
    if (reset) begin
      r_out_valid  <= 1'b0;
      r_out_data   <= '0;
      r_out_ch     <= '0;
      r_txn_count  <= '0;
      // Resetting last_grant to NUM_CH-1 makes channel 0 the first round-robin winner
      r_last_grant <= CW'(NUM_CH - 1);
    end else begin
      if (w_xfer) r_txn_count <= r_txn_count + 16'd1;
      if (w_load) begin
        r_out_valid  <= 1'b1;
        r_out_data   <= w_rd_data;
        r_out_ch     <= w_grant;
        r_last_grant <= w_grant;
      end else if (w_xfer) begin
        r_out_valid  <= 1'b0;
      end
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_ch    = r_out_ch;
  assign txn_count = r_txn_count;

endmodule

// File: tb/tb_multi_chan_driver.sv
// Testbench for multi_chan_driver.
// A queue-based reference model advances on every rising edge and pushes each
// word it expects to present into exp_q. A negedge monitor compares the visible
// DUT state with the model and pops exp_q on every completed output transfer.

module tb_multi_chan_driver;

  localparam int NUM_CH = 4;
  localparam int DATA_W = 8;
  localparam int DEPTH  = 4;
  localparam int CW     = 2;
  localparam int W      = CW + DATA_W;

  logic                     clk;
  logic                     reset;
  logic [NUM_CH-1:0]        in_valid;
  logic [NUM_CH*DATA_W-1:0] in_data;
  logic [NUM_CH-1:0]        in_ready;
  logic [NUM_CH-1:0]        ch_en;
  logic                     prio_mode;
  logic                     out_valid;
  logic [DATA_W-1:0]        out_data;
  logic [CW-1:0]            out_ch;
  logic                     out_ready;
  logic [15:0]              txn_count;

  multi_chan_driver #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .ch_en     (ch_en),
    .prio_mode (prio_mode),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ch    (out_ch),
    .out_ready (out_ready),
    .txn_count (txn_count)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  logic [DATA_W-1:0] mq [NUM_CH][$];
  logic              m_valid;
  logic [DATA_W-1:0] m_data;
  logic [CW-1:0]     m_ch;
  logic [15:0]       m_txn;
  int                m_last;
  logic [W-1:0]      exp_q[$];
  logic [W-1:0]      obs_q[$];
  logic [NUM_CH-1:0] m_rdy;

  int vectors;
  int miscompares;
  bit mon_en;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One rising edge of the specified behaviour, using the inputs present now.
  task automatic model_step();
    bit acc[NUM_CH];
    bit elig[NUM_CH];
    bit xfer;
    int g;
    int c;
    if (reset) begin
      for (int i = 0; i < NUM_CH; i++) mq[i].delete();
      m_valid = 1'b0;
      m_data  = '0;
      m_ch    = '0;
      m_txn   = '0;
      m_last  = NUM_CH - 1;
      exp_q.delete();
      return;
    end
    xfer = m_valid && out_ready;
    if (xfer) m_txn = m_txn + 16'd1;
    for (int i = 0; i < NUM_CH; i++) begin
      acc[i]  = in_valid[i] && (mq[i].size() < DEPTH);
      elig[i] = (mq[i].size() > 0) && ch_en[i];
    end
    g = -1;
    if (prio_mode) begin
      for (int i = 0; i < NUM_CH; i++) if (g < 0 && elig[i]) g = i;
    end else begin
      for (int k = 1; k <= NUM_CH; k++) begin
        c = (m_last + k) % NUM_CH;
        if (g < 0 && elig[c]) g = c;
      end
    end
    if ((!m_valid || out_ready) && g >= 0) begin
      m_data  = mq[g].pop_front();
      m_ch    = CW'(g);
      m_valid = 1'b1;
      m_last  = g;
      exp_q.push_back({m_ch, m_data});
    end else if (xfer) begin
      m_valid = 1'b0;
    end
    for (int i = 0; i < NUM_CH; i++) begin
      if (acc[i]) mq[i].push_back(in_data[i*DATA_W +: DATA_W]);
    end
  endtask

  // ---------------- driver ----------------
  task automatic tick();
    @(posedge clk);
    model_step();
    #2;
  endtask

  task automatic apply_reset();
    reset     = 1'b1;
    in_valid  = '0;
    out_ready = 1'b0;
    tick();
    reset     = 1'b0;
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    if (mon_en) begin
      for (int i = 0; i < NUM_CH; i++) m_rdy[i] = (mq[i].size() < DEPTH);
      check("state", {out_valid, out_ch, out_data, in_ready, txn_count},
                     {m_valid, m_ch, m_data, m_rdy, m_txn});
      if (!reset && out_valid && out_ready) begin
        obs_q.push_back({out_ch, out_data});
        if (exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL xfer: got %0h expected nothing (queue empty)", {out_ch, out_data});
        end else begin
          check("xfer", {out_ch, out_data}, exp_q.pop_front());
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  logic [W-1:0]  tmp;
  logic [CW-1:0] fp_exp [6];

  initial begin
    vectors     = 0;
    miscompares = 0;
    mon_en      = 0;
    reset       = 1'b1;
    in_valid    = '0;
    in_data     = '0;
    ch_en       = '1;
    prio_mode   = 1'b0;
    out_ready   = 1'b0;

    // Reset state
    tick();
    mon_en = 1;
    check("reset_state", {out_valid, out_ch, out_data, in_ready, txn_count},
                         {1'b0, 2'd0, 8'd0, 4'hf, 16'd0});
    tick();
    reset = 1'b0;

    // Single word on ch2: visible after edge N+1, counted after edge N+2
    out_ready = 1'b1;
    in_valid  = 4'b0100;
    in_data[2*DATA_W +: DATA_W] = 8'hA5;
    tick();
    in_valid = '0;
    tick();
    check("single_out", {out_valid, out_ch, out_data}, {1'b1, 2'd2, 8'hA5});
    tick();
    check("single_txn", txn_count, 16'd1);

    // Round-robin across four channels holding two words each
    apply_reset();
    prio_mode = 1'b0;
    in_valid  = '1;
    for (int w = 0; w < 2; w++) begin
      in_data = {8'h30 + 8'(w), 8'h20 + 8'(w), 8'h10 + 8'(w), 8'h00 + 8'(w)};
      tick();
    end
    in_valid = '0;
    obs_q.delete();
    out_ready = 1'b1;
    repeat (8) tick();
    check("rr_txn", txn_count, 16'd8);
    check("rr_count", obs_q.size(), 8);
    for (int k = 0; k < 8 && k < obs_q.size(); k++) begin
      tmp = obs_q[k];
      check("rr_seq", tmp[W-1 -: CW], k % NUM_CH);
    end

    // Fixed priority with ch0 and ch3 holding three words each
    apply_reset();
    prio_mode = 1'b1;
    in_valid  = 4'b1001;
    repeat (3) begin
      in_data = $urandom;
      tick();
    end
    in_valid = '0;
    obs_q.delete();
    out_ready = 1'b1;
    repeat (7) tick();
    fp_exp = '{2'd0, 2'd0, 2'd0, 2'd3, 2'd3, 2'd3};
    check("fp_count", obs_q.size(), 6);
    for (int k = 0; k < 6 && k < obs_q.size(); k++) begin
      tmp = obs_q[k];
      check("fp_seq", tmp[W-1 -: CW], fp_exp[k]);
    end

    // Backpressure: six offered on ch1, five accepted
    apply_reset();
    prio_mode = 1'b0;
    in_valid  = 4'b0010;
    for (int k = 0; k < 6; k++) begin
      in_data[1*DATA_W +: DATA_W] = 8'h40 + 8'(k);
      tick();
    end
    check("bp_full", in_ready[1], 1'b0);
    in_valid = '0;
    repeat (3) tick();
    check("bp_hold", {out_valid, out_data}, {1'b1, 8'h40});
    obs_q.delete();
    out_ready = 1'b1;
    repeat (7) tick();
    check("bp_count", obs_q.size(), 5);
    for (int k = 0; k < 5 && k < obs_q.size(); k++) begin
      tmp = obs_q[k];
      check("bp_order", tmp, {2'd1, 8'h40 + 8'(k)});
    end

    // Channel mask: ch0 holds data but is disabled
    apply_reset();
    ch_en     = 4'b1110;
    out_ready = 1'b1;
    in_valid  = 4'b0011;
    repeat (2) begin
      in_data = $urandom;
      tick();
    end
    in_valid = '0;
    obs_q.delete();
    repeat (6) tick();
    check("mask_count", obs_q.size(), 2);
    for (int k = 0; k < obs_q.size(); k++) begin
      tmp = obs_q[k];
      check("mask_ch0", (tmp[W-1 -: CW] == 2'd0), 1'b0);
    end
    // Reset mid-stream with a word presented and one buffered
    ch_en     = '1;
    out_ready = 1'b0;
    tick();
    check("pre_reset_valid", out_valid, 1'b1);
    reset    = 1'b1;
    in_valid = 4'b1111;
    tick();
    check("mid_reset", {out_valid, txn_count, in_ready}, {1'b0, 16'd0, 4'hf});
    in_valid = '0;
    reset    = 1'b0;
    out_ready = 1'b1;
    tick();
    check("post_reset_idle", out_valid, 1'b0);

    // Randomised traffic
    for (int n = 0; n < 3000; n++) begin
      in_valid  = NUM_CH'($urandom);
      in_data   = $urandom;
      ch_en     = ($urandom_range(0, 3) == 0) ? NUM_CH'($urandom) : '1;
      if ($urandom_range(0, 15) == 0) prio_mode = ~prio_mode;
      out_ready = ($urandom_range(0, 9) < 7);
      reset     = ($urandom_range(0, 299) == 0);
      tick();
    end

    // Drain everything left in flight
    reset     = 1'b0;
    in_valid  = '0;
    ch_en     = '1;
    out_ready = 1'b1;
    repeat (30) tick();
    check("drain_empty", exp_q.size(), 0);
    check("drain_idle", out_valid, 1'b0);

    mon_en = 0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
